// File: rtl/gate_tree_pipe.sv
// gate_tree_pipe
//
// Pipelined AND/OR reduction tree. Each transaction first forms x & y.
// The result is then reduced to a single bit through LEVELS = log2(WIDTH)
// levels of pair gates. The gates alternate between OR and AND, and the
// per-transaction mode bit selects which gate the first level uses
// (mode=0: level 1 is OR, mode=1: level 1 is AND). There is one register
// stage for the operand AND and one for each reduction level, so a result
// appears LEVELS+1 cycles after acceptance. The whole pipe moves together
// under a valid/ready handshake with full backpressure.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction present
//   in_ready   block accepts a transaction this cycle (= pipeline advance)
//   x, y       WIDTH-bit operands
//   mode       gate selection for the first reduction level
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out        reduction result
//   hit_cnt    (only with GATE_TREE_HITCNT_EN) saturating count of
//              delivered results equal to 1
//
// Optional feature macro: GATE_TREE_HITCNT_EN
//
// WIDTH must be a power of two and at least 2.

module gate_tree_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out
`ifdef GATE_TREE_HITCNT_EN
  ,
  output logic [15:0]      hit_cnt
`endif
);

  localparam int LEVELS   = $clog2(WIDTH);
  // All stages are packed back to back into one vector. The widths are
  // WIDTH, WIDTH/2, ..., 1, so the total is 2*WIDTH-1 bits.
  localparam int TREEBITS = 2 * WIDTH - 1;

  // Bit offset of stage k inside the packed tree vector.
  function automatic int levelOff(input int k);
    return 2 * WIDTH - 2 * (WIDTH >> k);
  endfunction

  logic [TREEBITS-1:0] tree_q, tree_d;
  logic [LEVELS:0]     valid_q;
  // Stage k holds the mode that stage k+1 needs, so the last stage needs no copy.
  logic [LEVELS-1:0]   mode_q, mode_d;
  logic                adv;

  // The pipe advances when the output slot is empty or is being drained.
  // A stall freezes every stage, including bubbles.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = valid_q[LEVELS];
  assign out       = tree_q[TREEBITS-1];

  // Next data for every stage. Level k combines adjacent bit pairs of
  // stage k-1. It uses OR when (k odd) XOR mode is set, and AND otherwise.
  always_comb begin
    tree_d = '0;
    tree_d[WIDTH-1:0] = x & y;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int j = 0; j < (WIDTH >> k); j++) begin
        if (((k % 2) == 1) ^ mode_q[k-1])
          tree_d[levelOff(k) + j] = tree_q[levelOff(k-1) + 2*j] | tree_q[levelOff(k-1) + 2*j + 1];
        else
          tree_d[levelOff(k) + j] = tree_q[levelOff(k-1) + 2*j] & tree_q[levelOff(k-1) + 2*j + 1];
      end
    end
  end

  // The mode bit shifts alongside its data.
  always_comb begin
    mode_d = '0;
    mode_d[0] = mode;
    for (int k = 1; k < LEVELS; k++) begin
      mode_d[k] = mode_q[k-1];
    end
  end

  // Data loads without a valid qualifier. Bubble contents are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q  <= '0;
      mode_q  <= '0;
      valid_q <= '0;
    end else if (adv) begin
      tree_q  <= tree_d;
      mode_q  <= mode_d;
      valid_q <= {valid_q[LEVELS-1:0], in_valid};
    end
  end

`ifdef GATE_TREE_HITCNT_EN
  logic [15:0] hitCnt_q, hitCnt_d;

  // Accepting an all-zero operand pair with mode=1 clears the counter.
  // This in-band clear wins over a coincident hit.
  always_comb begin
    hitCnt_d = hitCnt_q;
    if (in_valid && in_ready && (x == '0) && (y == '0) && mode)
      hitCnt_d = '0;
    else if (out_valid && out_ready && out && (hitCnt_q != 16'hFFFF))
      hitCnt_d = hitCnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hitCnt_q <= '0;
    else
      hitCnt_q <= hitCnt_d;
  end

  assign hit_cnt = hitCnt_q;
`endif

endmodule

// File: tb/tb_gate_tree_pipe.sv
// tb_gate_tree_pipe
//
// Directed bench for gate_tree_pipe with WIDTH=8. Inputs are driven on the
// falling edge and outputs are sampled just after it. Expected results
// are hand-derived from the reduction rules.

module tb_gate_tree_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] xIn;
  logic [WIDTH-1:0] yIn;
  logic             mode;
  logic             outValid;
  logic             outReady;
  logic             out;
`ifdef GATE_TREE_HITCNT_EN
  logic [15:0]      hitCnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  gate_tree_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .x         (xIn),
    .y         (yIn),
    .mode      (mode),
    .out_valid (outValid),
    .out_ready (outReady),
    .out       (out)
`ifdef GATE_TREE_HITCNT_EN
    ,
    .hit_cnt   (hitCnt)
`endif
  );

  always #5 clk = ~clk;

  // Safety net in case some wait misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Send one transaction and wait for its result. Then check the
  // acceptance, the latency (4 cycles after the accepting edge) and the value.
  task automatic applyStimulus(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                               input logic m, input logic expOut);
    int cycles;
    @(negedge clk);
    xIn      = xv;
    yIn      = yv;
    mode     = m;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput({tag, "_rdy"}, {31'd0, inReady}, 32'd1);
    @(posedge clk);
    cycles = 0;
    do begin
      @(negedge clk);
      inValid = 1'b0;
      cycles++;
      #1;
    end while (!outValid && cycles < 20);
    checkOutput({tag, "_lat"}, cycles, 32'd4);
    checkOutput({tag, "_out"}, {31'd0, out}, {31'd0, expOut});
  endtask

  // Six back-to-back transactions alternate between 05/FF (result 1) and
  // 03/03 (result 0). The consumer stalls for 3 cycles when the first result shows up.
  task automatic streamTest();
    int   sent      = 0;
    int   recv      = 0;
    int   stallLeft = 0;
    int   cycles    = 0;
    int   extra     = 0;
    bit   stallDone = 1'b0;
    while (recv < 6 && cycles < 80) begin
      @(negedge clk);
      cycles++;
      if (outValid && !stallDone) begin
        stallDone = 1'b1;
        stallLeft = 3;
      end
      outReady = (stallLeft == 0);
      inValid  = (sent < 6);
      xIn      = (sent % 2 == 0) ? 8'h05 : 8'h03;
      yIn      = (sent % 2 == 0) ? 8'hFF : 8'h03;
      mode     = 1'b0;
      #1;
      if (stallLeft > 0) begin
        checkOutput("stall_rdy", {31'd0, inReady}, 32'd0);
        checkOutput("stall_vld", {31'd0, outValid}, 32'd1);
        checkOutput("stall_out", {31'd0, out}, (recv % 2 == 0) ? 32'd1 : 32'd0);
        stallLeft--;
      end else if (outValid) begin
        checkOutput($sformatf("strm_out%0d", recv), {31'd0, out}, (recv % 2 == 0) ? 32'd1 : 32'd0);
        recv++;
      end
      if (inValid && inReady) sent++;
    end
    checkOutput("strm_cnt", recv, 32'd6);
    checkOutput("strm_sent", sent, 32'd6);
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (6) begin
      #1;
      if (outValid) extra++;
      @(negedge clk);
    end
    checkOutput("strm_extra", extra, 32'd0);
  endtask

  // Fill four stages with result-1 transactions and reset between edges.
  // The first fresh transaction must then come out as its own result (0).
  task automatic midResetTest();
    int stale = 0;
    @(negedge clk);
    outReady = 1'b1;
    inValid  = 1'b1;
    mode     = 1'b0;
    xIn      = 8'hFF;
    yIn      = 8'hFF;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("prerst_vld", {31'd0, outValid}, 32'd1);
    rstN    = 1'b0;
    inValid = 1'b0;
    #1;
    checkOutput("rst_vld", {31'd0, outValid}, 32'd0);
    checkOutput("rst_rdy", {31'd0, inReady}, 32'd1);
    checkOutput("rst_out", {31'd0, out}, 32'd0);
`ifdef GATE_TREE_HITCNT_EN
    checkOutput("rst_hit", {16'd0, hitCnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (outValid) stale++;
    end
    checkOutput("rst_stale", stale, 32'd0);
    applyStimulus("postrst", 8'h03, 8'h03, 1'b0, 1'b0);
  endtask

  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    xIn      = '0;
    yIn      = '0;
    mode     = 1'b0;
    outReady = 1'b1;
    #3;
    checkOutput("init_vld", {31'd0, outValid}, 32'd0);
    checkOutput("init_rdy", {31'd0, inReady}, 32'd1);
    checkOutput("init_out", {31'd0, out}, 32'd0);
`ifdef GATE_TREE_HITCNT_EN
    checkOutput("init_hit", {16'd0, hitCnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Expected values derived level by level (L1 / L2 / L3).
    applyStimulus("ff_m0", 8'hFF, 8'hFF, 1'b0, 1'b1);
    applyStimulus("03_m0", 8'h03, 8'h03, 1'b0, 1'b0);
    applyStimulus("05_m0", 8'h05, 8'hFF, 1'b0, 1'b1);
    applyStimulus("0f_m1", 8'h0F, 8'h0F, 1'b1, 1'b0);
    applyStimulus("ff_m1", 8'hFF, 8'hFF, 1'b1, 1'b1);
    applyStimulus("aa_m0", 8'hAA, 8'hFF, 1'b0, 1'b1);
    applyStimulus("aa_m1", 8'hAA, 8'hFF, 1'b1, 1'b0);
    applyStimulus("clr_m1", 8'h00, 8'h00, 1'b1, 1'b0);
`ifdef GATE_TREE_HITCNT_EN
    checkOutput("clr_hit", {16'd0, hitCnt}, 32'd0);
`endif

    streamTest();
`ifdef GATE_TREE_HITCNT_EN
    checkOutput("strm_hit", {16'd0, hitCnt}, 32'd3);
`endif

    midResetTest();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
